// File: rtl/kyber512_hash_arbiter_pkg.sv
// Shared Kyber hash-arbiter definitions: defaults, requester indices, FSM encoding.
package kyber512_hash_arbiter_pkg;

    // Arbiter sizing defaults
    localparam int unsigned KY_NUM_REQ     = 3;
    localparam int unsigned KY_TIMEOUT_CYC = 4096;
    localparam int unsigned OWNER_W        = 2;

    // Requester slots on the shared hash core
    localparam int unsigned REQ_KEM_HASH = 0;  // pre/post KEM hash
    localparam int unsigned REQ_CPA_ENC  = 1;  // CPA encrypt
    localparam int unsigned REQ_CPA_DEC  = 2;  // CPA decrypt

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

endpackage : kyber512_hash_arbiter_pkg

// File: rtl/kyber512_rr_pick.sv
// Combinational round-robin winner search starting at ptr_i, wrapping modulo N.
module kyber512_rr_pick #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    // First set request at or after the pointer wins
    always_comb begin
        valid_o  = 1'b0;
        idx_o    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = 32'(ptr_i) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDX_W'(cand);
            if (!valid_o && req_i[cand_idx]) begin
                valid_o = 1'b1;
                idx_o   = cand_idx;
            end
        end
    end

endmodule : kyber512_rr_pick

// File: rtl/kyber512_hash_arbiter.sv
// Round-robin arbiter granting the shared Kyber hash core to one requester at a time.
module kyber512_hash_arbiter
    import kyber512_hash_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ     = KY_NUM_REQ,
    parameter int unsigned TIMEOUT_CYC = KY_TIMEOUT_CYC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [OWNER_W-1:0] o_owner,
    output logic               o_core_enable,
    input  logic               i_core_done,
    output logic [NUM_REQ-1:0] o_done,
    output logic [NUM_REQ-1:0] o_timeout,
    output logic               o_busy
);

    localparam int unsigned       IDX_W    = OWNER_W;
    localparam int unsigned       CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_REQ - 1);

    arb_state_e         state_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   owner_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] done_q;
    logic [NUM_REQ-1:0] timeout_q;
    logic               enable_q;
    logic               busy_q;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;

    kyber512_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i   (i_req),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // Arbiter FSM with registered grant, pulse and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            timeout_q <= '0;
            enable_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            enable_q  <= 1'b0;
            done_q    <= '0;
            timeout_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_q  <= ST_GRANT;
                        owner_q  <= pick_idx;
                        gnt_q    <= NUM_REQ'(1) << pick_idx;
                        enable_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion takes priority over a coincident timeout
                    if (i_core_done) begin
                        state_q <= ST_RELEASE;
                        done_q  <= gnt_q;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= ST_RELEASE;
                        timeout_q <= gnt_q;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    state_q  <= ST_IDLE;
                    gnt_q    <= '0;
                    owner_q  <= '0;
                    busy_q   <= 1'b0;
                    rr_ptr_q <= (owner_q == IDX_LAST) ? '0 : owner_q + 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_gnt         = gnt_q;
    assign o_owner       = owner_q;
    assign o_core_enable = enable_q;
    assign o_done        = done_q;
    assign o_timeout     = timeout_q;
    assign o_busy        = busy_q;

endmodule : kyber512_hash_arbiter

// File: doc/kyber512_hash_arbiter.md
KYBER512_HASH_ARBITER -- requirements
Module: kyber512_hash_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3: number of requesters sharing the hash core.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 4096: maximum cycles the core may stay busy before a forced release.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port i_req, input, NUM_REQ: level request, one bit per requester.
REQ-006 SHALL have port o_gnt, output, NUM_REQ: one-hot grant, held for the whole operation.
REQ-007 SHALL have port o_owner, output, 2: index of the current grantee; 0 when idle.
REQ-008 SHALL have port o_core_enable, output, 1: one-cycle start pulse to the shared hash core.
REQ-009 SHALL have port i_core_done, input, 1: one-cycle completion pulse from the core.
REQ-010 SHALL have port o_done, output, NUM_REQ: one-cycle completion pulse to the owning requester.
REQ-011 SHALL have port o_timeout, output, NUM_REQ: one-cycle error pulse to the owner on forced release.
REQ-012 SHALL have port o_busy, output, 1: high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT, WAIT and RELEASE.
REQ-014 IDLE: when any i_req bit is high, SHALL select a winner by round-robin from pointer rr_ptr and go to GRANT next cycle.
REQ-015 Round-robin SHALL search indices rr_ptr, rr_ptr+1, ... modulo NUM_REQ; first set bit wins.
REQ-016 GRANT (one cycle): SHALL assert o_gnt[winner], drive o_owner = winner, pulse o_core_enable, clear the timeout counter, then go to WAIT.
REQ-017 WAIT: SHALL hold o_gnt and o_owner, increment the timeout counter each cycle, and keep o_core_enable low.
REQ-018 WAIT with i_core_done = 1: SHALL pulse o_done[owner] in the next cycle (RELEASE).
REQ-019 WAIT with counter = TIMEOUT_CYC-1 and no i_core_done: SHALL pulse o_timeout[owner] in RELEASE instead.
REQ-020 If i_core_done and the timeout condition occur in the same cycle, done SHALL win and o_timeout stays 0.
REQ-021 RELEASE (one cycle): SHALL deassert o_gnt, set rr_ptr = owner+1 modulo NUM_REQ, and go to IDLE.
REQ-022 Minimum request-to-core-enable latency SHALL be 1 cycle: request seen in IDLE, enable pulses in GRANT.
REQ-023 Back-to-back operations SHALL incur exactly 2 idle-to-idle overhead cycles (RELEASE, IDLE) between grants.
REQ-024 Requester dropping i_req during WAIT SHALL NOT abort the operation; o_done still pulses.
REQ-025 i_core_done outside WAIT SHALL be ignored.
REQ-026 o_gnt SHALL always be one-hot or zero, and o_done/o_timeout SHALL never be high in the same cycle.
REQ-027 The timeout counter SHALL be $clog2(TIMEOUT_CYC) bits and SHALL saturate, not wrap.

Reset
REQ-028 On rst_n low, the block SHALL asynchronously go to IDLE, with rr_ptr = 0, counter = 0 and every output at 0.
REQ-029 Reset mid-operation SHALL abandon the grant with no o_done or o_timeout pulse; the core is reset by the same rst_n.

Structure
REQ-030 The state encodings, NUM_REQ and TIMEOUT_CYC defaults, and requester index constants (0 = pre/post KEM hash, 1 = CPA encrypt, 2 = CPA decrypt) SHALL live in the shared Kyber package.
REQ-031 The round-robin winner search SHALL be a sub-module, kyber512_rr_pick, that is purely combinational.
REQ-032 All outputs SHALL be registered.

Verification
REQ-033 Scenario: reset, then i_req = 3'b010 -> o_gnt = 010 and o_core_enable pulse one cycle later; i_core_done after 10 cycles -> o_done = 010 for one cycle.
REQ-034 Scenario: i_req = 3'b111 held, core done each time -> grant order 001, 010, 100, 001, with 2 cycles between grants.
REQ-035 Scenario: TIMEOUT_CYC = 16, i_req = 001, core never done -> o_timeout = 001 in cycle 17 after grant, then o_gnt = 0.
REQ-036 Scenario: i_core_done on the same cycle the counter hits 15 (TIMEOUT_CYC = 16) -> o_done pulses, o_timeout stays 0.
REQ-037 Scenario: rst_n low during WAIT -> all outputs 0 immediately; after release, i_req = 100 -> granted first (rr_ptr = 0 but only bit 2 set).
REQ-038 Scenario: requester 0 drops i_req mid-WAIT, and a spurious i_core_done arrives in IDLE -> op completes with o_done = 001; spurious pulse causes no output.
